// File: rtl/sensor_fast_pkg.sv
// Shared widths and state encoding for the sensor_fast path.
// Used by the peak finder and the downstream holding register.
package sensor_fast_pkg;

   localparam int POS_W = 9;
   localparam int VAL_W = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_e;

endpackage

// File: rtl/line_peak_finder.sv
// Scans one sensor line and reports the brightest qualifying pixel.
// Presents index/value with a one-cycle latch pulse at end of line.
module line_peak_finder
   import sensor_fast_pkg::*;
#(
   parameter int LINE_LEN = 512,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line_start,
   input  logic             pix_valid,
   input  logic [VAL_W-1:0] pix_data,
   input  logic [VAL_W-1:0] threshold,
   output logic [POS_W-1:0] max_pos,
   output logic [VAL_W-1:0] max_val,
   output logic             found,
   output logic             latch,
   output logic             line_err
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [POS_W-1:0] LAST_IDX = POS_W'(LINE_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e           state_q,    state_d;
   logic [POS_W-1:0] idx_q,      idx_d;
   logic [VAL_W-1:0] thr_q,      thr_d;
   logic [TMO_W-1:0] tmo_q,      tmo_d;
   logic             hit_q,      hit_d;
   logic [VAL_W-1:0] run_val_q,  run_val_d;
   logic [POS_W-1:0] run_pos_q,  run_pos_d;
   logic [POS_W-1:0] max_pos_q,  max_pos_d;
   logic [VAL_W-1:0] max_val_q,  max_val_d;
   logic             found_q,    found_d;
   logic             latch_q,    latch_d;
   logic             line_err_q, line_err_d;

   logic             beat_start;
   logic             beat_cont;
   logic             base_hit;
   logic [VAL_W-1:0] base_val;
   logic [POS_W-1:0] base_pos;
   logic [POS_W-1:0] cur_idx;
   logic [VAL_W-1:0] cmp_thr;
   logic             qual;
   logic             upd;
   logic             nxt_hit;
   logic [VAL_W-1:0] nxt_val;
   logic [POS_W-1:0] nxt_pos;

   // State register and all datapath flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         thr_q      <= '0;
         tmo_q      <= '0;
         hit_q      <= 1'b0;
         run_val_q  <= '0;
         run_pos_q  <= '0;
         max_pos_q  <= '0;
         max_val_q  <= '0;
         found_q    <= 1'b0;
         latch_q    <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         thr_q      <= thr_d;
         tmo_q      <= tmo_d;
         hit_q      <= hit_d;
         run_val_q  <= run_val_d;
         run_pos_q  <= run_pos_d;
         max_pos_q  <= max_pos_d;
         max_val_q  <= max_val_d;
         found_q    <= found_d;
         latch_q    <= latch_d;
         line_err_q <= line_err_d;
      end
   end

   // Next state, beat acceptance, running peak and end-of-line outputs.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      thr_d      = thr_q;
      tmo_d      = tmo_q;
      hit_d      = hit_q;
      run_val_d  = run_val_q;
      run_pos_d  = run_pos_q;
      max_pos_d  = max_pos_q;
      max_val_d  = max_val_q;
      found_d    = found_q;
      latch_d    = 1'b0;
      line_err_d = 1'b0;
      beat_start = 1'b0;
      beat_cont  = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (line_start && pix_valid) begin
               beat_start = 1'b1;
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            if (line_start && pix_valid) begin
               // Restart: drop the partial line, this pixel is index 0.
               beat_start = 1'b1;
               line_err_d = 1'b1;
            end else if (pix_valid) begin
               beat_cont = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               line_err_d = 1'b1;
               tmo_d      = '0;
               state_d    = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A starting beat compares against a fresh, empty peak and the live threshold.
      base_hit = beat_start ? 1'b0 : hit_q;
      base_val = beat_start ? '0 : run_val_q;
      base_pos = beat_start ? '0 : run_pos_q;
      cur_idx  = beat_start ? '0 : idx_q;
      cmp_thr  = beat_start ? threshold : thr_q;

      // Strict compare keeps the lowest index on equal values.
      qual    = (pix_data >= cmp_thr);
      upd     = qual && (!base_hit || (pix_data > base_val));
      nxt_hit = base_hit | qual;
      nxt_val = upd ? pix_data : base_val;
      nxt_pos = upd ? cur_idx : base_pos;

      if (beat_start || beat_cont) begin
         hit_d     = nxt_hit;
         run_val_d = nxt_val;
         run_pos_d = nxt_pos;
         idx_d     = cur_idx + POS_W'(1);
         tmo_d     = '0;
      end

      if (beat_start) begin
         thr_d = threshold;
      end

      // End of line is the compare at the last index, never a counter wrap.
      if (beat_cont && (idx_q == LAST_IDX)) begin
         state_d   = S_DONE;
         idx_d     = '0;
         latch_d   = 1'b1;
         found_d   = nxt_hit;
         max_pos_d = nxt_hit ? nxt_pos : '0;
         max_val_d = nxt_hit ? nxt_val : '0;
      end
   end

   assign max_pos  = max_pos_q;
   assign max_val  = max_val_q;
   assign found    = found_q;
   assign latch    = latch_q;
   assign line_err = line_err_q;

endmodule

// File: tb/tb_line_peak_finder.sv
// Self-checking bench for line_peak_finder with LINE_LEN=8, TIMEOUT=4.
// Table-driven lines plus hand sequences for restart, timeout and reset.
module tb_line_peak_finder;

   logic       clk;
   logic       rst;
   logic       line_start;
   logic       pix_valid;
   logic [9:0] pix_data;
   logic [9:0] threshold;
   logic [8:0] max_pos;
   logic [9:0] max_val;
   logic       found;
   logic       latch;
   logic       line_err;

   line_peak_finder #(
      .LINE_LEN (8),
      .TIMEOUT  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .threshold  (threshold),
      .max_pos    (max_pos),
      .max_val    (max_val),
      .found      (found),
      .latch      (latch),
      .line_err   (line_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] pos;
      logic [9:0] val;
      logic       fnd;
   } exp_t;

   typedef struct {
      logic [9:0]       thr;
      int               gap;
      logic [7:0][9:0]  pix;
      exp_t             exp;
   } vec_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   lat_cnt = 0;
   int   err_cnt = 0;
   int   exp_lat = 0;
   int   exp_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0][9:0] px(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7);
      logic [7:0][9:0] p;
      p[0] = 10'(a0); p[1] = 10'(a1); p[2] = 10'(a2); p[3] = 10'(a3);
      p[4] = 10'(a4); p[5] = 10'(a5); p[6] = 10'(a6); p[7] = 10'(a7);
      return p;
   endfunction

   function automatic exp_t mk_exp(input int pos, input int val, input logic fnd);
      exp_t e;
      e.pos = 9'(pos);
      e.val = 10'(val);
      e.fnd = fnd;
      return e;
   endfunction

   // Monitor: scoreboard pops on latch, pulse and output-hold checks every cycle.
   logic       prev_latch = 1'b0;
   logic       prev_err   = 1'b0;
   bit         prev_rst   = 1'b1;
   logic [19:0] prev_out  = '0;

   always @(negedge clk) begin
      exp_t e;
      if (latch === 1'b1) begin
         lat_cnt++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_latch: got latch=1, expected none");
         end else begin
            e = sb.pop_front();
            chk("max_pos", 32'(max_pos), 32'(e.pos));
            chk("max_val", 32'(max_val), 32'(e.val));
            chk("found", 32'(found), 32'(e.fnd));
         end
      end
      if (line_err === 1'b1) err_cnt++;
      if (!prev_rst) begin
         chk("no_coincident", 32'(latch & line_err), 32'(0));
         chk("latch_width", 32'(prev_latch & latch), 32'(0));
         chk("err_width", 32'(prev_err & line_err), 32'(0));
         if (latch !== 1'b1)
            chk("out_hold", 32'({max_pos, max_val, found} != prev_out), 32'(0));
      end
      prev_latch = latch;
      prev_err   = line_err;
      prev_out   = {max_pos, max_val, found};
      prev_rst   = rst;
   end

   task automatic send_beat(input logic ls, input logic [9:0] d);
      line_start = ls;
      pix_valid  = 1'b1;
      pix_data   = d;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      pix_valid  = 1'b0;
      pix_data   = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Threshold is scrambled after the first beat: only the sampled value may count.
   task automatic run_line(input vec_t v);
      for (int i = 0; i < 8; i++) begin
         threshold = (i == 0) ? v.thr : (10'd1023 - v.thr);
         if (i == 7) begin
            sb.push_back(v.exp);
            exp_lat++;
         end
         send_beat(i == 0, v.pix[i]);
         if (i < 7) idle(v.gap);
      end
      chk("latch_latency", 32'(latch), 32'(1));
   endtask

   vec_t vt[7];
   int   base;

   initial begin
      vt[0] = '{thr: 100, gap: 0, pix: px(5, 200, 300, 150, 300, 20, 0, 99),
                exp: mk_exp(2, 300, 1'b1)};
      vt[1] = '{thr: 100, gap: 0, pix: px(99, 99, 99, 99, 99, 99, 99, 99),
                exp: mk_exp(0, 0, 1'b0)};
      vt[2] = '{thr: 100, gap: 3, pix: px(5, 200, 300, 150, 300, 20, 0, 99),
                exp: mk_exp(2, 300, 1'b1)};
      vt[3] = '{thr: 100, gap: 0, pix: px(100, 0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(0, 100, 1'b1)};
      vt[4] = '{thr: 100, gap: 1, pix: px(0, 0, 0, 0, 0, 0, 500, 1023),
                exp: mk_exp(7, 1023, 1'b1)};
      vt[5] = '{thr: 100, gap: 0, pix: px(500, 500, 500, 500, 500, 500, 500, 500),
                exp: mk_exp(0, 500, 1'b1)};
      vt[6] = '{thr: 0, gap: 0, pix: px(0, 0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(0, 0, 1'b1)};

      rst        = 1'b1;
      line_start = 1'b0;
      pix_valid  = 1'b0;
      pix_data   = '0;
      threshold  = 10'd100;
      idle(3);
      chk("rst_max_pos", 32'(max_pos), 32'(0));
      chk("rst_max_val", 32'(max_val), 32'(0));
      chk("rst_found", 32'(found), 32'(0));
      chk("rst_latch", 32'(latch), 32'(0));
      chk("rst_line_err", 32'(line_err), 32'(0));
      rst = 1'b0;
      idle(2);

      // Lines 1..n back to back: each next line starts during the DONE cycle.
      run_line(vt[0]);
      run_line(vt[1]);
      idle(1);
      chk("below_thr_found", 32'(found), 32'(0));
      for (int k = 2; k < 7; k++) run_line(vt[k]);
      idle(3);
      chk("no_err_tables", 32'(err_cnt), 32'(exp_err));

      // Restart mid-line.
      threshold = 10'd100;
      for (int i = 0; i < 5; i++) send_beat(i == 0, vt[0].pix[i]);
      exp_err++;
      threshold = 10'd100;
      send_beat(1'b1, 10'd0);
      chk("restart_err", 32'(line_err), 32'(1));
      for (int i = 1; i < 8; i++) begin
         if (i == 7) begin
            sb.push_back(mk_exp(6, 900, 1'b1));
            exp_lat++;
         end
         send_beat(1'b0, (i == 6) ? 10'd900 : 10'd0);
      end
      idle(3);
      chk("restart_err_cnt", 32'(err_cnt), 32'(exp_err));

      // Timeout after 3 beats.
      base = err_cnt;
      for (int i = 0; i < 3; i++) send_beat(i == 0, 10'd700);
      exp_err++;
      idle(8);
      chk("timeout_err", 32'(err_cnt - base), 32'(1));
      chk("timeout_hold_pos", 32'(max_pos), 32'(6));
      chk("timeout_hold_val", 32'(max_val), 32'(900));
      send_beat(1'b0, 10'd1000);
      idle(2);
      chk("stray_beat_ignored", 32'(lat_cnt), 32'(exp_lat));

      // Reset mid-line.
      for (int i = 0; i < 4; i++) send_beat(i == 0, 10'd800);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("mid_rst_pos", 32'(max_pos), 32'(0));
      chk("mid_rst_val", 32'(max_val), 32'(0));
      chk("mid_rst_found", 32'(found), 32'(0));
      idle(2);
      run_line(vt[0]);
      idle(4);

      chk("sb_empty", 32'(sb.size()), 32'(0));
      chk("latch_count", 32'(lat_cnt), 32'(exp_lat));
      chk("err_count", 32'(err_cnt), 32'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
